// File: rtl/instr_fetch_decode.sv
// Purpose: word-addressed instruction memory with a RISC-V RV32I field/immediate decoder.
// Latency: memory read is combinational; decode is 1 cycle (DECODE_REG_OUT_EN) or 0 cycles (default).
// Backpressure: none; a new instr and a memory write are accepted every cycle.
module instr_fetch_decode #(
    parameter int MEM_WORDS = 1024,
    parameter int IDX_BITS  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] adr,
    input  logic        load,
    input  logic [31:0] in,
    output logic [31:0] out,
    input  logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  fun3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  fun7,
    output logic [31:0] imm
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // NOP is addi x0,x0,0: only the opcode field is non-zero.
    localparam logic [6:0] NOP_OPCODE = 7'h13;

    logic [31:0]         mem [MEM_WORDS];
    logic [IDX_BITS-1:0] idx;

    // Byte offset and bits above the array depth are dropped, so addresses wrap.
    assign idx = adr[IDX_BITS+1:2];
    assign out = mem[idx];

    // Memory is never reset; writes go through even while rst is high.
    always_ff @(posedge clk) begin
        if (load) begin
            mem[idx] <= in;
        end
    end

    logic [6:0]  d_opcode;
    logic [4:0]  d_rd;
    logic [2:0]  d_fun3;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic [6:0]  d_fun7;
    logic [31:0] d_imm;

    // Raw field slices plus format-dependent sign-extended immediate.
    always_comb begin
        d_opcode = instr[6:0];
        d_rd     = instr[11:7];
        d_fun3   = instr[14:12];
        d_rs1    = instr[19:15];
        d_rs2    = instr[24:20];
        d_fun7   = instr[31:25];
        d_imm    = 32'h0;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR:
                d_imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                d_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                d_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                d_imm = {instr[31:12], 12'h000};
            OP_JAL:
                d_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                d_imm = 32'h0;
        endcase
    end

`ifdef DECODE_REG_OUT_EN
    // Registered decode; reset forces the NOP decode at once, overriding any pending word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode <= NOP_OPCODE;
            rd     <= '0;
            fun3   <= '0;
            rs1    <= '0;
            rs2    <= '0;
            fun7   <= '0;
            imm    <= '0;
        end else begin
            opcode <= d_opcode;
            rd     <= d_rd;
            fun3   <= d_fun3;
            rs1    <= d_rs1;
            rs2    <= d_rs2;
            fun7   <= d_fun7;
            imm    <= d_imm;
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, adr[31:IDX_BITS+2], adr[1:0]};
`else
    // Zero-latency decode; rst has no effect on these outputs.
    always_comb begin
        opcode = d_opcode;
        rd     = d_rd;
        fun3   = d_fun3;
        rs1    = d_rs1;
        rs2    = d_rs2;
        fun7   = d_fun7;
        imm    = d_imm;
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, rst, adr[31:IDX_BITS+2], adr[1:0], NOP_OPCODE};
`endif

endmodule

// File: tb/tb_instr_fetch_decode.sv
module tb_instr_fetch_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr;
    logic        load;
    logic [31:0] in;
    logic [31:0] out;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  fun3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  fun7;
    logic [31:0] imm;

    int compared   = 0;
    int mismatched = 0;

    instr_fetch_decode #(.MEM_WORDS(1024), .IDX_BITS(10)) dut (
        .clk(clk), .rst(rst), .adr(adr), .load(load), .in(in), .out(out),
        .instr(instr), .opcode(opcode), .rd(rd), .fun3(fun3), .rs1(rs1),
        .rs2(rs2), .fun7(fun7), .imm(imm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  fun3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  fun7;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic check_fields(input string tag, input vec_t v);
        check({tag, ".opcode"}, {25'b0, opcode}, {25'b0, v.opcode});
        check({tag, ".rd"},     {27'b0, rd},     {27'b0, v.rd});
        check({tag, ".fun3"},   {29'b0, fun3},   {29'b0, v.fun3});
        check({tag, ".rs1"},    {27'b0, rs1},    {27'b0, v.rs1});
        check({tag, ".rs2"},    {27'b0, rs2},    {27'b0, v.rs2});
        check({tag, ".fun7"},   {25'b0, fun7},   {25'b0, v.fun7});
        check({tag, ".imm"},    imm,             v.imm);
    endtask

    // Drive instr just after a rising edge, then sample once the decode is due.
    task automatic apply_instr(input logic [31:0] w);
        instr = w;
`ifdef DECODE_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic mem_write(input logic [31:0] a, input logic [31:0] d);
        adr  = a;
        in   = d;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic mem_read(input string nm, input logic [31:0] a, input logic [31:0] exp);
        adr = a;
        #1;
        check(nm, out, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t nop_v;
    vec_t lui_v;
    vec_t addi_v;

    initial begin
        //               instr          opc    rd     f3    rs1    rs2    f7     imm
        vecs[0]  = '{32'h00500093, 7'h13, 5'd1,  3'd0, 5'd0,  5'd5,  7'h00, 32'h00000005}; // addi x1,x0,5
        vecs[1]  = '{32'hFE20AE23, 7'h23, 5'h1C, 3'd2, 5'd1,  5'd2,  7'h7F, 32'hFFFFFFFC}; // sw x2,-4(x1)
        vecs[2]  = '{32'hFE000CE3, 7'h63, 5'h19, 3'd0, 5'd0,  5'd0,  7'h7F, 32'hFFFFFFF8}; // beq -8
        vecs[3]  = '{32'hFFDFF06F, 7'h6F, 5'd0,  3'd7, 5'h1F, 5'h1D, 7'h7F, 32'hFFFFFFFC}; // jal x0,-4
        vecs[4]  = '{32'h123452B7, 7'h37, 5'd5,  3'd5, 5'd8,  5'd3,  7'h09, 32'h12345000}; // lui x5
        vecs[5]  = '{32'h002081B3, 7'h33, 5'd3,  3'd0, 5'd1,  5'd2,  7'h00, 32'h00000000}; // add (R)
        vecs[6]  = '{32'hFFC12083, 7'h03, 5'd1,  3'd2, 5'd2,  5'h1C, 7'h7F, 32'hFFFFFFFC}; // lw x1,-4(x2)
        vecs[7]  = '{32'h00001097, 7'h17, 5'd1,  3'd1, 5'd0,  5'd0,  7'h00, 32'h00001000}; // auipc
        vecs[8]  = '{32'hFF0080E7, 7'h67, 5'd1,  3'd0, 5'd1,  5'h10, 7'h7F, 32'hFFFFFFF0}; // jalr -16
        vecs[9]  = '{32'hFFFFFFFF, 7'h7F, 5'h1F, 3'd7, 5'h1F, 5'h1F, 7'h7F, 32'h00000000}; // unlisted
        vecs[10] = '{32'h00000463, 7'h63, 5'd8,  3'd0, 5'd0,  5'd0,  7'h00, 32'h00000008}; // beq +8
        vecs[11] = '{32'h0020A423, 7'h23, 5'd8,  3'd2, 5'd1,  5'd2,  7'h00, 32'h00000008}; // sw +8
        vecs[12] = '{32'h008000EF, 7'h6F, 5'd1,  3'd0, 5'd0,  5'd8,  7'h00, 32'h00000008}; // jal +8
        nop_v  = '{32'h00000013, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0};
        lui_v  = vecs[4];
        addi_v = vecs[0];

        rst   = 1'b1;
        adr   = 32'h0;
        load  = 1'b0;
        in    = 32'h0;
        instr = 32'h123452B7;
        #2;
`ifdef DECODE_REG_OUT_EN
        check_fields("reset", nop_v);
`else
        check_fields("reset_nochange", lui_v);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Memory write, wrap and byte-offset aliasing
        mem_write(32'h0, 32'h00500093);
        mem_read("mem_0x0",    32'h0,    32'h00500093);
        mem_read("mem_0x1002", 32'h1002, 32'h00500093);
        mem_read("mem_0x3",    32'h3,    32'h00500093);
        mem_write(32'hFFC, 32'hDEADBEEF);
        mem_read("mem_0xFFC",  32'hFFC,  32'hDEADBEEF);
        mem_read("mem_0x1FFC", 32'h1FFC, 32'hDEADBEEF);
        mem_read("mem_0x0_after_top", 32'h0, 32'h00500093);

        for (int i = 0; i < 13; i++) begin
            apply_instr(vecs[i].instr);
            check_fields($sformatf("vec%0d", i), vecs[i]);
        end

`ifdef DECODE_REG_OUT_EN
        // New word is held off until the next edge.
        apply_instr(32'h123452B7);
        instr = 32'h00500093;
        #1;
        check("latency_hold.imm", imm, 32'h12345000);
        @(posedge clk);
        #1;
        check("latency_update.imm", imm, 32'h00000005);
        instr = 32'h123452B7;
        @(posedge clk);
        #1;
`else
        apply_instr(32'h123452B7);
`endif

        // Asynchronous reset mid-cycle with a pending word on instr
        #2;
        instr = 32'hFE20AE23;
        rst   = 1'b1;
        #1;
`ifdef DECODE_REG_OUT_EN
        check_fields("async_rst", nop_v);
`else
        check_fields("rst_ignored", vecs[1]);
`endif
        mem_read("rst_mem_0x0", 32'h0, 32'h00500093);

        // Write during reset still lands
        @(posedge clk);
        #1;
        mem_write(32'h8, 32'hCAFEF00D);
        mem_read("rst_write_0x8", 32'h8, 32'hCAFEF00D);
        mem_read("rst_keep_0x0",  32'h0, 32'h00500093);
`ifdef DECODE_REG_OUT_EN
        check_fields("rst_held", nop_v);
`endif

        // Release reset; decode resumes on the next edge
        rst   = 1'b0;
        instr = 32'h00500093;
        #1;
`ifdef DECODE_REG_OUT_EN
        check("rst_release_pre.imm", imm, 32'h0);
        @(posedge clk);
        #1;
`endif
        check_fields("rst_release", addi_v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instr_fetch_decode.md
INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 Parameter MEM_WORDS, default 1024, instruction memory depth in 32-bit words (power of two).
REQ-002 Parameter IDX_BITS, default 10, word-index width, equal to log2(MEM_WORDS).
REQ-003 clk  input  1  sole clock; all sequential logic on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 adr  input  32  memory byte address.
REQ-006 load  input  1  memory write enable.
REQ-007 in  input  32  memory write data.
REQ-008 out  output  32  memory read data.
REQ-009 instr  input  32  instruction word to decode.
REQ-010 opcode  output  7  instr[6:0].
REQ-011 rd  output  5  instr[11:7].
REQ-012 fun3  output  3  instr[14:12].
REQ-013 rs1  output  5  instr[19:15].
REQ-014 rs2  output  5  instr[24:20].
REQ-015 fun7  output  7  instr[31:25].
REQ-016 imm  output  32  sign-extended immediate.

Function
REQ-017 Memory is MEM_WORDS x 32 bits, word-indexed by adr[IDX_BITS+1:2]; adr[1:0] and upper bits are ignored, so addresses wrap modulo MEM_WORDS*4.
REQ-018 Read is combinational: out = mem[index] at all times, including during reset.
REQ-019 Write: on posedge clk with load=1, mem[index] <= in; out reflects the new word after that edge.
REQ-020 Field outputs rd, fun3, rs1, rs2, fun7 and opcode are raw bit slices of instr, independent of format.
REQ-021 imm for opcodes 0010011, 0000011, 1100111 (I-type): sext(instr[31:20]).
REQ-022 imm for opcode 0100011 (S-type): sext({instr[31:25],instr[11:7]}).
REQ-023 imm for opcode 1100011 (B-type): sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
REQ-024 imm for opcodes 0110111 and 0010111 (U-type): {instr[31:12],12'h000}.
REQ-025 imm for opcode 1101111 (J-type): sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
REQ-026 imm for opcode 0110011 (R-type) and for any unlisted opcode: 32'h0.
REQ-027 Decoded outputs are registered: they update on the posedge after instr is applied (1-cycle latency).

Reset
REQ-028 While rst=1, decoded outputs equal the NOP decode (instr 32'h00000013): opcode=7'h13, all other fields and imm = 0.
REQ-029 Reset does not clear or alter memory contents; a load=1 write at a clock edge proceeds regardless of rst.
REQ-030 After rst deasserts, decode resumes on the next posedge; a reset asserted mid-stream overrides the pending decode immediately.

Configuration
REQ-031 Macro DECODE_REG_OUT_EN: when defined, decoded outputs are registered as in REQ-027 and REQ-028.
REQ-032 When DECODE_REG_OUT_EN is undefined, decoded outputs are combinational functions of instr with zero latency; rst then affects no decoded output.

Verification
REQ-033 Write 32'h00500093 at adr 0x0, then read adr 0x0 and adr 0x1002 -> out = 32'h00500093 for both (1024-word wrap).
REQ-034 instr=32'h00500093 -> after one edge: opcode=7'h13, rd=1, fun3=0, rs1=0, imm=32'h5.
REQ-035 instr=32'hFE20AE23 (sw) -> opcode=7'h23, rs1=1, rs2=2, fun3=2, imm=32'hFFFFFFFC.
REQ-036 instr=32'hFE000CE3 (beq) -> imm=32'hFFFFFFF8; instr=32'hFFDFF06F (jal) -> imm=32'hFFFFFFFC.
REQ-037 instr=32'h123452B7 (lui) -> opcode=7'h37, rd=5, imm=32'h12345000.
REQ-038 Assert rst asynchronously while valid decoded outputs are held -> opcode=7'h13 and all other decoded outputs = 0 immediately; memory word at 0x0 still reads back unchanged.
